// File: rtl/uart_hram_cmd_bridge.sv
// Serial command-frame to HyperRAM request bridge: collects fixed-length UART frames,
// issues hyper_xface read/write requests and streams response words back a byte at a time.
module uart_hram_cmd_bridge #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned FRAME_TO  = 1200000,
  parameter int unsigned RD_TO     = 4096,
  parameter int unsigned CONST_VAL = 259
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_rcv,
  input  logic [7:0]          rx_data,
  input  logic                tx_ready,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                busy,
  input  logic                rd_rdy,
  input  logic [DATA_W-1:0]   rd_d,
  output logic                rd_req,
  output logic                wr_req,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wr_d,
  output logic [DATA_W/8-1:0] wr_byte_en,
  output logic [5:0]          rd_num_dwords
);
  localparam int unsigned NBW = DATA_W / 8;
  localparam int unsigned NB  = NBW + 1;
  localparam int unsigned FW  = NB * 8;
  localparam int unsigned BCW = $clog2(NB);
  localparam int unsigned BIW = $clog2(NBW);
  localparam int unsigned AW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned FTW = $clog2(FRAME_TO + 1);
  localparam int unsigned RTW = $clog2(RD_TO + 1);
  localparam int unsigned PW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [DATA_W-1:0] ErrWord = {NBW{8'hEE}};

  typedef enum logic [2:0] {StCollect, StExec, StIssue, StCapture, StResp} state_e;
  state_e state_q, state_d;

  logic [FW-1:0]     frame_q;
  logic [BCW-1:0]    byte_cnt_q;
  logic [FTW-1:0]    idle_q;
  logic [7:0]        err_cnt_q, ovr_cnt_q;
  logic [DATA_W-1:0] count_q, resp_word_q;
  logic              resp_buf_q, tx_phase_q, is_read_q;
  logic [5:0]        resp_nw_q, word_idx_q, idx_q;
  logic [BIW-1:0]    byte_idx_q;
  logic [RTW-1:0]    rd_to_q;
  logic [DATA_W-1:0] rbuf_q [2**AW];

  logic [7:0]        cmd;
  logic [DATA_W-1:0] payload, cur_word;
  logic [PW-1:0]     pay_ext;
  logic [5:0]        burst_n;
  logic              burst_ok, exec_issue, rx_last, cap_done, rd_timeout, last_byte, issue_go;
  logic [7:0]        tx_byte;

  always_comb begin
    cmd        = frame_q[FW-1 -: 8];
    payload    = frame_q[DATA_W-1:0];
    pay_ext    = PW'(payload);
    burst_n    = payload[5:0];
    burst_ok   = (burst_n != 6'd0) && (32'(burst_n) <= MAX_BURST);
    exec_issue = (cmd == 8'h03) || (cmd == 8'h05) || ((cmd == 8'h08) && burst_ok);
    rx_last    = rx_rcv && (byte_cnt_q == BCW'(NB - 1));
    cap_done   = rd_rdy && ((idx_q + 6'd1) == rd_num_dwords);
    rd_timeout = !cap_done && (rd_to_q == RTW'(RD_TO - 1));
    cur_word   = resp_buf_q ? rbuf_q[word_idx_q[AW-1:0]] : resp_word_q;
    tx_byte    = 8'(cur_word >> {BIW'(NBW - 1) - byte_idx_q, 3'b000});
    last_byte  = (byte_idx_q == BIW'(NBW - 1)) && (word_idx_q == resp_nw_q - 6'd1);
    issue_go   = (state_q == StIssue) && !busy;
    wr_req     = issue_go && !is_read_q;
    rd_req     = issue_go && is_read_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (rx_last) state_d = StExec;
      StExec:    state_d = exec_issue ? StIssue : StResp;
      StIssue:   if (!busy) state_d = is_read_q ? StCapture : StResp;
      StCapture: if (cap_done || rd_timeout) state_d = StResp;
      StResp:    if (tx_phase_q && !tx_ready && last_byte) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StCollect;
    else       state_q <= state_d;
  end

  // Read buffer carries no reset; it only holds data captured from the RAM.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StCapture) && rd_rdy) rbuf_q[idx_q[AW-1:0]] <= rd_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q       <= '0;
      byte_cnt_q    <= '0;
      idle_q        <= '0;
      err_cnt_q     <= '0;
      ovr_cnt_q     <= '0;
      count_q       <= '0;
      resp_word_q   <= '0;
      resp_buf_q    <= 1'b0;
      resp_nw_q     <= 6'd1;
      word_idx_q    <= '0;
      byte_idx_q    <= '0;
      tx_phase_q    <= 1'b0;
      is_read_q     <= 1'b0;
      idx_q         <= '0;
      rd_to_q       <= '0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      addr          <= '0;
      wr_d          <= '0;
      wr_byte_en    <= '1;
      rd_num_dwords <= 6'd1;
    end else begin
      tx_start <= 1'b0;
      if (rx_rcv && (state_q != StCollect) && (ovr_cnt_q != 8'hFF)) ovr_cnt_q <= ovr_cnt_q + 8'd1;
      unique case (state_q)
        StCollect: begin
          if (rx_rcv) begin
            frame_q    <= {frame_q[FW-9:0], rx_data};
            idle_q     <= '0;
            byte_cnt_q <= rx_last ? '0 : byte_cnt_q + BCW'(1);
          end else if (byte_cnt_q != '0) begin
            // Stale partial frame: drop it so the next byte is taken as a command.
            if (idle_q == FTW'(FRAME_TO - 1)) begin
              byte_cnt_q <= '0;
              idle_q     <= '0;
            end else begin
              idle_q <= idle_q + FTW'(1);
            end
          end
        end
        StExec: begin
          resp_buf_q  <= 1'b0;
          resp_nw_q   <= 6'd1;
          word_idx_q  <= '0;
          byte_idx_q  <= '0;
          tx_phase_q  <= 1'b0;
          resp_word_q <= payload;
          case (cmd)
            8'h01: addr <= pay_ext[ADDR_W-1:0];
            8'h02: wr_d <= payload;
            8'h03: begin is_read_q <= 1'b0; resp_word_q <= DATA_W'(3); end
            8'h04: resp_word_q <= rbuf_q[0];
            8'h05: begin
              is_read_q     <= 1'b1;
              rd_num_dwords <= 6'd1;
              resp_word_q   <= DATA_W'(5);
            end
            8'h06: begin resp_word_q <= count_q; count_q <= count_q + DATA_W'(1); end
            8'h07: resp_word_q <= DATA_W'(CONST_VAL);
            8'h08: begin
              if (burst_ok) begin
                is_read_q     <= 1'b1;
                rd_num_dwords <= burst_n;
                resp_buf_q    <= 1'b1;
                resp_nw_q     <= burst_n;
              end else begin
                resp_word_q <= ErrWord;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              end
            end
            8'h09: wr_byte_en <= payload[NBW-1:0];
            8'h0A: resp_word_q <= DATA_W'({err_cnt_q, ovr_cnt_q});
            default: begin
              resp_word_q <= ErrWord;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          endcase
        end
        StIssue: begin
          if (!busy) begin
            idx_q   <= '0;
            rd_to_q <= '0;
          end
        end
        StCapture: begin
          if (rd_rdy) idx_q <= idx_q + 6'd1;
          if (rd_timeout) begin
            resp_word_q <= ErrWord;
            resp_buf_q  <= 1'b0;
            resp_nw_q   <= 6'd1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else if (!cap_done) begin
            rd_to_q <= rd_to_q + RTW'(1);
          end
        end
        StResp: begin
          if (!tx_phase_q) begin
            if (tx_ready) begin
              tx_start   <= 1'b1;
              tx_data    <= tx_byte;
              tx_phase_q <= 1'b1;
            end
          end else if (!tx_ready) begin
            tx_phase_q <= 1'b0;
            if (byte_idx_q == BIW'(NBW - 1)) begin
              byte_idx_q <= '0;
              word_idx_q <= word_idx_q + 6'd1;
            end else begin
              byte_idx_q <= byte_idx_q + BIW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_hram_cmd_bridge.sv
// Scoreboard bench for uart_hram_cmd_bridge: expected response bytes are queued as frames
// are sent and popped as the UART transmitter model sees each tx_start.
module tb_uart_hram_cmd_bridge;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned FRAME_TO = 300;
  localparam int unsigned RD_TO    = 4096;

  logic              clk = 1'b0;
  logic              reset, rx_rcv, tx_ready, tx_start, busy, rd_rdy, rd_req, wr_req;
  logic [7:0]        rx_data, tx_data;
  logic [DATA_W-1:0] rd_d, wr_d;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wr_byte_en;
  logic [5:0]        rd_num_dwords;

  always #5 clk = ~clk;

  uart_hram_cmd_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(8), .FRAME_TO(FRAME_TO), .RD_TO(RD_TO),
    .CONST_VAL(259)
  ) dut (
    .clk(clk), .reset(reset), .rx_rcv(rx_rcv), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .rd_rdy(rd_rdy), .rd_d(rd_d),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_d(wr_d), .wr_byte_en(wr_byte_en),
    .rd_num_dwords(rd_num_dwords)
  );

  int n_checks = 0, n_pass = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_words[$];
  int tx_cnt = 0, tx_extra = 0, tx_hold = 0, wr_cnt = 0, rd_cnt = 0, busy_viol = 0, cyc = 0;
  int busy_fall_cyc = -1, wr_cyc = -2, rd_go = 0;
  bit rd_en = 1'b1;
  logic busy_prev = 1'b0;
  logic [31:0] wr_addr_s, wr_d_s;
  logic [3:0]  wr_be_s;
  logic [5:0]  rd_num_s;
  int err_m = 0, ovr_m = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Monitor and UART transmitter model, sampling 1ns before each rising edge.
  initial begin
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
      if ((wr_req || rd_req) && busy) busy_viol++;
      if (wr_req) begin
        wr_cnt++; wr_cyc = cyc; wr_addr_s = addr; wr_d_s = wr_d; wr_be_s = wr_byte_en;
      end
      if (rd_req) begin
        rd_cnt++; rd_num_s = rd_num_dwords;
        if (rd_en) rd_go = int'(rd_num_dwords);
      end
      if (tx_start) begin
        tx_cnt++;
        if (exp_q.size() == 0) tx_extra++;
        else check_eq("tx_byte", tx_data, exp_q.pop_front());
        tx_ready = 1'b0;
        tx_hold  = 8;
      end else if (tx_hold > 0) begin
        tx_hold--;
        if (tx_hold == 0) tx_ready = 1'b1;
      end
    end
  end

  // HyperRAM read data model.
  initial begin
    rd_rdy = 1'b0;
    rd_d   = '0;
    forever begin
      @(negedge clk);
      if (rd_go > 0) begin
        int n;
        n = rd_go;
        rd_go = 0;
        for (int i = 0; i < n; i++) begin
          repeat (2) @(negedge clk);
          rd_rdy = 1'b1;
          rd_d   = (rd_words.size() > 0) ? rd_words.pop_front() : 32'hDEAD_0000;
          @(negedge clk);
          rd_rdy = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_rcv = 1'b1; rx_data = b;
    @(negedge clk); rx_rcv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] pl);
    send_byte(c);
    for (int i = 3; i >= 0; i--) send_byte(pl[i*8 +: 8]);
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin @(negedge clk); k++; end
    check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (12) @(negedge clk);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] c, input logic [31:0] pl,
                         input logic [31:0] resp);
    expect_word(resp);
    send_frame(c, pl);
    drain(tag, 600);
  endtask

  task automatic wait_resp_start(input string tag);
    int k;
    k = 0;
    while (exp_q.size() == 4 && k < 300) begin @(negedge clk); k++; end
    check_eq({tag, "_started"}, 64'(exp_q.size() < 4), 64'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_tx_start"}, 64'(tx_start), 64'd0);
    check_eq({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    check_eq({tag, "_reqs"}, 64'({rd_req, wr_req}), 64'd0);
    check_eq({tag, "_addr"}, 64'(addr), 64'd0);
    check_eq({tag, "_wr_d"}, 64'(wr_d), 64'd0);
    check_eq({tag, "_byte_en"}, 64'(wr_byte_en), 64'hF);
    check_eq({tag, "_rd_num"}, 64'(rd_num_dwords), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int t0, w0, r0, c0;
    reset = 1'b1; rx_rcv = 1'b0; rx_data = '0; tx_ready = 1'b1; busy = 1'b0;
    repeat (3) @(negedge clk);
    #4 check_reset_outs("rst");
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);

    // Address/load/write sequence.
    t0 = tx_cnt; w0 = wr_cnt;
    run_cmd("addr", 8'h01, 32'h0000_0010, 32'h0000_0010);
    run_cmd("load", 8'h02, 32'hCAFE_BABE, 32'hCAFE_BABE);
    run_cmd("write", 8'h03, 32'h0, 32'h0000_0003);
    check_eq("wr_pulses", 64'(wr_cnt - w0), 64'd1);
    check_eq("wr_addr", 64'(wr_addr_s), 64'h10);
    check_eq("wr_data", 64'(wr_d_s), 64'hCAFE_BABE);
    check_eq("wr_be", 64'(wr_be_s), 64'hF);
    check_eq("wr_tx_bytes", 64'(tx_cnt - t0), 64'd12);

    // Write held off by busy.
    w0 = wr_cnt;
    busy = 1'b1;
    expect_word(32'h3);
    send_frame(8'h03, 32'h0);
    repeat (50) @(negedge clk);
    check_eq("busy_hold", 64'(wr_cnt - w0), 64'd0);
    busy = 1'b0;
    drain("busy_write", 600);
    check_eq("busy_wr_pulses", 64'(wr_cnt - w0), 64'd1);
    check_eq("busy_wr_cycle", 64'(wr_cyc), 64'(busy_fall_cyc));
    check_eq("busy_violation", 64'(busy_viol), 64'd0);

    // Burst of three then READ of buffer head.
    r0 = rd_cnt;
    rd_words.push_back(32'h1111_1111);
    rd_words.push_back(32'h2222_2222);
    rd_words.push_back(32'h3333_3333);
    expect_word(32'h1111_1111); expect_word(32'h2222_2222); expect_word(32'h3333_3333);
    send_frame(8'h08, 32'd3);
    drain("burst3", 800);
    check_eq("burst_rd_pulses", 64'(rd_cnt - r0), 64'd1);
    check_eq("burst_rd_num", 64'(rd_num_s), 64'd3);
    run_cmd("read_buf", 8'h04, 32'h0, 32'h1111_1111);

    // Invalid burst lengths and unknown command.
    r0 = rd_cnt;
    run_cmd("burst0", 8'h08, 32'd0, 32'hEEEE_EEEE); err_m++;
    run_cmd("burst9", 8'h08, 32'd9, 32'hEEEE_EEEE); err_m++;
    run_cmd("bad_cmd", 8'h55, 32'd0, 32'hEEEE_EEEE); err_m++;
    check_eq("err_no_rd", 64'(rd_cnt - r0), 64'd0);
    run_cmd("status1", 8'h0A, 32'h0, 32'((err_m << 8) | ovr_m));

    // Partial frame discarded after idle timeout.
    send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    repeat (FRAME_TO + 10) @(negedge clk);
    run_cmd("resync_const", 8'h07, 32'h0, 32'h0000_0103);

    // Bytes arriving mid-response are dropped and counted.
    expect_word(32'h0);
    send_frame(8'h06, 32'h0);
    wait_resp_start("ovr");
    for (int i = 0; i < 4; i++) begin send_byte(8'hAA); ovr_m++; end
    drain("count0", 600);
    run_cmd("count1", 8'h06, 32'h0, 32'h1);
    run_cmd("status2", 8'h0A, 32'h0, 32'((err_m << 8) | ovr_m));

    // READ_REQ with no read data returns the error word after the timeout.
    rd_en = 1'b0;
    c0 = cyc;
    expect_word(32'hEEEE_EEEE); err_m++;
    send_frame(8'h05, 32'h0);
    drain("rd_timeout", 6000);
    check_eq("rd_timeout_late", 64'((cyc - c0) >= int'(RD_TO)), 64'd1);
    rd_en = 1'b1;
    run_cmd("status3", 8'h0A, 32'h0, 32'((err_m << 8) | ovr_m));

    // Reset in the middle of a response.
    expect_word(32'h0000_0103);
    send_frame(8'h07, 32'h0);
    wait_resp_start("mid_rst");
    @(negedge clk) reset = 1'b1;
    @(negedge clk); #4;
    check_reset_outs("mid_rst");
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    err_m = 0; ovr_m = 0;
    repeat (12) @(negedge clk);
    run_cmd("post_rst_status", 8'h0A, 32'h0, 32'h0);
    run_cmd("post_rst_count", 8'h06, 32'h0, 32'h0);
    run_cmd("post_rst_const", 8'h07, 32'h0, 32'h0000_0103);

    check_eq("tx_extra_bytes", 64'(tx_extra), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_hram_cmd_bridge.md
Name: uart_hram_cmd_bridge

Overview:
Parametrised serial-command-to-HyperRAM bridge. It decodes fixed-length command frames from a UART receiver and drives the hyper_xface request interface. Responses go back through a UART transmitter. Successor to the inline 32-bit serial FSM, adding:
- configurable word width
- multi-word burst reads into a buffer
- busy-aware request issue
- frame resync timeout, error/overrun counters
- exact response byte count (no padding byte)

Parameters:
DATA_W, 32, data word width; multiple of 8, 16..64
ADDR_W, 32, HyperRAM address width
MAX_BURST, 8, read buffer depth in words; 1..63
FRAME_TO, 1200000, idle clk cycles after which a partial frame is discarded
RD_TO, 4096, clk cycles allowed from rd_req to last rd_rdy
CONST_VAL, 259, value returned by CONST command

Ports:
clk  in  1  system clock (hram_clk domain)
reset  in  1  synchronous, active-high reset
rx_rcv  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
tx_ready  in  1  UART transmitter idle
tx_start  out  1  one-cycle transmit strobe
tx_data  out  8  byte to transmit, valid with tx_start
busy  in  1  hyper_xface busy
rd_rdy  in  1  one-cycle strobe: rd_d valid
rd_d  in  DATA_W  read word
rd_req  out  1  one-cycle read request
wr_req  out  1  one-cycle write request
addr  out  ADDR_W  access address
wr_d  out  DATA_W  write word
wr_byte_en  out  DATA_W/8  write byte enables
rd_num_dwords  out  6  words per read request

Behaviour:
- Reset values: rd_req=0, wr_req=0, tx_start=0, tx_data=0, addr=0, wr_d=0, wr_byte_en=all ones, rd_num_dwords=1.
- Reset also clears: count, err_cnt, ovr_cnt, byte counter, buffer write index; FSM goes to COLLECT.
- Reset mid-operation abandons any frame, request or response immediately.
- Frame format: NB=1+DATA_W/8 bytes. First byte is the command; the rest are the payload, MSB first.
- Frame execution starts the cycle after the NB-th rx_rcv.
- Frame resync: in COLLECT with a partial frame, FRAME_TO cycles without rx_rcv reset the byte counter to 0.
- Overrun: rx_rcv outside COLLECT drops the byte, increments ovr_cnt (saturating at 255), and leaves the byte counter unchanged.
- FSM states:
  - COLLECT: gathers bytes; on the NB-th byte goes to EXEC.
  - EXEC: decodes the command; goes to ISSUE (WRITE/READ_REQ/BURST) or directly to RESP.
  - ISSUE: waits while busy=1. With busy=0, pulses wr_req or rd_req for exactly one cycle, then goes to RESP (write) or CAPTURE (read).
  - CAPTURE: each rd_rdy stores rd_d at buf[idx] and increments idx.
    - When idx==rd_num_dwords, go to RESP.
    - If RD_TO expires first, respond with the error word and increment err_cnt.
    - rd_rdy in any other state is ignored.
  - RESP: sends response words MSB byte first, then returns to COLLECT.
- Commands and responses:
  - 0x01 ADDR: addr<=payload[ADDR_W-1:0]; echo payload.
  - 0x02 LOAD: wr_d<=payload; echo payload.
  - 0x03 WRITE: write request; respond 0x03.
  - 0x04 READ: respond buf[0]; no RAM access.
  - 0x05 READ_REQ: rd_num_dwords<=1; read; respond 0x05 after capture.
  - 0x06 COUNT: respond count, then count<=count+1; count wraps at 2^DATA_W.
  - 0x07 CONST: respond CONST_VAL.
  - 0x08 BURST: N=payload[5:0].
    - If 1<=N<=MAX_BURST: rd_num_dwords<=N; read; respond buf[0..N-1] back-to-back.
    - Otherwise: error word, err_cnt++, no request.
  - 0x09 BYTE_EN: wr_byte_en<=payload low bits; echo payload.
  - 0x0A STATUS: respond zero-extended {err_cnt[7:0], ovr_cnt[7:0]}.
  - Other command: error word (every byte 0xEE), err_cnt++ (saturating at 255).
- Non-response commands leave all registers unchanged.
- TX handshake, per byte:
  - Wait for tx_ready=1, then drive tx_start=1 for one cycle with tx_data.
  - Wait for tx_ready=0, then tx_ready=1, before the next byte.
  - Exactly DATA_W/8 bytes are sent per response word.

Test Plan:
- Default params. Frames ADDR 0x00000010, LOAD 0xCAFEBABE, WRITE -> exactly one wr_req cycle with addr=0x10, wr_d=0xCAFEBABE, wr_byte_en=0xF; responses 00 00 00 10, CA FE BA BE, 00 00 00 03; 12 bytes total.
- busy held high 50 cycles during WRITE -> wr_req asserted only on the first cycle after busy falls; never while busy=1.
- BURST N=3, model returns 0x11111111, 0x22222222, 0x33333333 -> rd_num_dwords=3, one rd_req pulse, 12 response bytes in that order. A following READ returns 0x11111111.
- BURST N=0 and N=9, plus command 0x55 -> three 0xEEEEEEEE responses, no rd_req; STATUS then returns 0x00000300.
- Send 3 bytes, idle FRAME_TO cycles, then a full CONST frame -> response 00 00 01 03. Bytes sent during RESP are dropped: STATUS shows ovr_cnt equal to that count.
- READ_REQ with rd_rdy never asserted -> error word after RD_TO cycles. Reset asserted mid-RESP -> tx_start=0 next cycle, outputs at reset values, a next frame is accepted normally.
